// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute sequencer for a small accumulator CPU.
//
// Fetches one instruction word from memory into an instruction register,
// presents opcode/operand to an external controller for one EXEC cycle, and
// then acts on the controller's decisions. The controller can request a halt,
// a jump, a data-memory access or a conditional skip.
//
// Ports
//   clk, rst_n            clock and synchronous active-low reset
//   opcode, operand       fields of the instruction register
//   instr_valid           high only in EXEC; controller outputs are sampled then
//   jump, skip, memRead,
//   memWrite, Halt        controller decisions for the current instruction
//   acc_zero              accumulator-is-zero flag, used by skip
//   resume                leaves HALT and restarts fetching at pc
//   mem_req, mem_we,
//   mem_addr              memory request, write flag, address
//   mem_ack, mem_rdata    completion strobe and read data
//   pc, halted            program counter and HALT indicator
//
// Memory handshake: mem_req/mem_we/mem_addr stay constant while mem_req is
// high; a transfer completes on any rising edge where mem_req and mem_ack are
// both high. mem_ack with mem_req low has no effect.
module instr_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              instr_valid,
    input  logic              jump,
    input  logic              skip,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              Halt,
    input  logic              acc_zero,
    input  logic              resume,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        DMEM  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [DATA_W-1:0] ir, ir_nx;
    logic              we_lat, we_lat_nx;
    // Cleared by reset so the first cycle after a reset edge issues no
    // request and ignores any stale mem_ack; set forever afterwards.
    logic              live;

    assign opcode  = ir[DATA_W-1 -: 3];
    assign operand = ir[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= ADDR_W'(RESET_PC);
            ir     <= '0;
            we_lat <= 1'b0;
            live   <= 1'b0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            ir     <= ir_nx;
            we_lat <= we_lat_nx;
            live   <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        ir_nx       = ir;
        we_lat_nx   = we_lat;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = pc;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            FETCH: begin
                mem_req = live;
                if (live && mem_ack) begin
                    ir_nx    = mem_rdata;
                    pc_nx    = pc + ADDR_W'(1);
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                // Priority: Halt > jump > data access > skip.
                if (Halt) begin
                    state_nx = HALT;
                end else if (jump) begin
                    pc_nx    = operand;
                    state_nx = FETCH;
                end else if (memRead || memWrite) begin
                    we_lat_nx = memWrite;
                    state_nx  = DMEM;
                end else begin
                    // pc already points past this instruction, so one more
                    // increment steps over the next one.
                    if (skip && acc_zero) begin
                        pc_nx = pc + ADDR_W'(1);
                    end
                    state_nx = FETCH;
                end
            end
            DMEM: begin
                mem_req  = 1'b1;
                mem_we   = we_lat;
                mem_addr = operand;
                if (mem_ack) begin
                    state_nx = FETCH;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer (default parameters: 5-bit address,
// 8-bit instruction, reset pc 0). The bench plays both memory and controller.
// Inputs change and outputs are sampled at the falling clock edge.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       instr_valid;
    logic       jump, skip, memRead, memWrite, Halt, acc_zero, resume;
    logic       mem_req, mem_we;
    logic [4:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [4:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .operand    (operand),
        .instr_valid(instr_valid),
        .jump       (jump),
        .skip       (skip),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .Halt       (Halt),
        .acc_zero   (acc_zero),
        .resume     (resume),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Complete a FETCH with an immediate ack; leaves the DUT in EXEC.
    task automatic fetch_instr(input logic [7:0] ins);
        mem_rdata = ins;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
    endtask

    // Drive controller decisions for one EXEC cycle.
    task automatic exec_ctl(input logic j, input logic s, input logic r,
                            input logic w, input logic h, input logic az);
        jump = j; skip = s; memRead = r; memWrite = w; Halt = h; acc_zero = az;
        tick();
        jump = 0; skip = 0; memRead = 0; memWrite = 0; Halt = 0; acc_zero = 0;
    endtask

    initial begin
        rst_n = 0; jump = 0; skip = 0; memRead = 0; memWrite = 0; Halt = 0;
        acc_zero = 0; resume = 0; mem_ack = 0; mem_rdata = 8'h00;
        tick();
        tick();
        check("rst_pc", 32'(pc), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_operand", 32'(operand), 0);

        rst_n = 1;
        tick();
        check("fetch0_req", 32'(mem_req), 1);
        check("fetch0_addr", 32'(mem_addr), 0);
        check("fetch0_we", 32'(mem_we), 0);

        fetch_instr(8'h22);
        check("exec0_valid", 32'(instr_valid), 1);
        check("exec0_opcode", 32'(opcode), 1);
        check("exec0_operand", 32'(operand), 2);
        check("exec0_pc", 32'(pc), 1);
        check("exec0_mem_req", 32'(mem_req), 0);
        exec_ctl(0, 0, 0, 0, 0, 0);
        check("fetch1_addr", 32'(mem_addr), 1);
        check("fetch1_req", 32'(mem_req), 1);
        check("fetch1_valid", 32'(instr_valid), 0);

        // Jump to 0x13.
        fetch_instr(8'h33);
        exec_ctl(1, 0, 0, 0, 0, 0);
        check("jump_pc", 32'(pc), 32'h13);
        check("jump_fetch_addr", 32'(mem_addr), 32'h13);

        // Skip taken at pc=5.
        fetch_instr(8'h24);
        exec_ctl(1, 0, 0, 0, 0, 0);
        fetch_instr(8'h40);
        check("skip_pc_after_fetch", 32'(pc), 5);
        exec_ctl(0, 1, 0, 0, 0, 1);
        check("skip_taken_addr", 32'(mem_addr), 6);

        // Skip not taken at pc=5.
        fetch_instr(8'h24);
        exec_ctl(1, 0, 0, 0, 0, 0);
        fetch_instr(8'h40);
        exec_ctl(0, 1, 0, 0, 0, 0);
        check("skip_not_taken_addr", 32'(mem_addr), 5);

        // jump outranks memWrite and skip.
        fetch_instr(8'h24);
        exec_ctl(1, 1, 0, 1, 0, 1);
        check("prio_jump_addr", 32'(mem_addr), 4);
        check("prio_jump_we", 32'(mem_we), 0);

        // Halt outranks jump; HALT holds for 10 cycles.
        fetch_instr(8'h40);
        exec_ctl(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            check("halt_flags", 32'({halted, mem_req, instr_valid}), 32'b100);
            tick();
        end
        check("halt_pc", 32'(pc), 5);
        check("halt_opcode", 32'(opcode), 2);
        resume = 1;
        tick();
        resume = 0;
        check("resume_halted", 32'(halted), 0);
        check("resume_addr", 32'(mem_addr), 5);
        check("resume_req", 32'(mem_req), 1);

        // memWrite to 0x0A with ack three cycles late; outranks skip.
        fetch_instr(8'hCA);
        exec_ctl(0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            check("dmem_w_req", 32'(mem_req), 1);
            check("dmem_w_we", 32'(mem_we), 1);
            check("dmem_w_addr", 32'(mem_addr), 32'h0A);
            if (i == 3) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        check("after_w_addr", 32'(mem_addr), 6);
        check("after_w_we", 32'(mem_we), 0);
        check("after_w_opcode", 32'(opcode), 6);

        // memRead from 3.
        fetch_instr(8'hA3);
        exec_ctl(0, 0, 1, 0, 0, 0);
        check("dmem_r_req", 32'(mem_req), 1);
        check("dmem_r_we", 32'(mem_we), 0);
        check("dmem_r_addr", 32'(mem_addr), 3);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check("after_r_addr", 32'(mem_addr), 7);

        // pc wrap from 31 to 0.
        fetch_instr(8'h1F);
        exec_ctl(1, 0, 0, 0, 0, 0);
        check("wrap_fetch_addr", 32'(mem_addr), 31);
        fetch_instr(8'h00);
        check("wrap_pc", 32'(pc), 0);
        exec_ctl(0, 0, 0, 0, 0, 0);
        check("wrap_next_addr", 32'(mem_addr), 0);

        // Reset during a DMEM wait, with a pending ack.
        fetch_instr(8'hC5);
        exec_ctl(0, 0, 0, 1, 0, 0);
        check("pre_rst_dmem_addr", 32'(mem_addr), 5);
        rst_n   = 0;
        mem_ack = 1;
        tick();
        check("rst_dmem_pc", 32'(pc), 0);
        check("rst_dmem_req", 32'(mem_req), 0);
        check("rst_dmem_we", 32'(mem_we), 0);
        check("rst_dmem_opcode", 32'(opcode), 0);
        rst_n = 1;
        tick();
        check("post_rst_ack_ignored", 32'(instr_valid), 0);
        check("post_rst_pc", 32'(pc), 0);
        check("post_rst_req", 32'(mem_req), 1);
        mem_ack = 0;

        // Reset while halted.
        fetch_instr(8'h40);
        exec_ctl(0, 0, 0, 0, 1, 0);
        check("halt2_halted", 32'(halted), 1);
        rst_n = 0;
        tick();
        check("rst_halt_halted", 32'(halted), 0);
        check("rst_halt_pc", 32'(pc), 0);
        rst_n = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
